// File: rtl/pp_sequencer.sv
// pp_sequencer: programmable micro-sequencer driving the accumulator datapath control word.
// Optional PP_SEQ_STEP_EN adds a `step` input that gates fetch/PC advance in RUN.
module pp_sequencer #(
  parameter int DEPTH = 32,
  parameter int NREG = 4,
  parameter int ALUW = 3,
  localparam int AW = $clog2(DEPTH),
  localparam int RW = $clog2(NREG),
  localparam int IW = 2 + AW + ALUW + 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
`ifdef PP_SEQ_STEP_EN
  input  logic            step,
`endif
  input  logic            prog_we,
  input  logic [AW-1:0]   prog_addr,
  input  logic [IW-1:0]   prog_wdata,
  input  logic            CY_in,
  output logic            busy,
  output logic            halted,
  output logic [AW-1:0]   PC,
  output logic [NREG-1:0] RegAddr,
  output logic [ALUW-1:0] ALUCode,
  output logic            Reg_CE,
  output logic            CY_CE,
  output logic            A_CE,
  output logic            ResetCY
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state, state_d;
  logic [IW-1:0] mem [DEPTH];
  logic [IW-1:0] instr;
  logic [1:0] kind;
  logic [AW-1:0] field, pc_d, pc_inc;
  logic [NREG-1:0] reg_d;
  logic [ALUW-1:0] alu_d;
  logic [3:0] str_d, str;
  logic adv;
  assign instr = mem[PC];
  assign kind = instr[IW-1 -: 2];
  assign field = instr[ALUW+4 +: AW];
  assign pc_inc = PC + AW'(1);
  assign busy = state == RUN;
  assign halted = state == HALTED;
  assign {Reg_CE, CY_CE, A_CE, ResetCY} = str;
`ifdef PP_SEQ_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif
  // writes are dropped while running so the executing program stays stable
  always_ff @(posedge clk)
    if (prog_we && state != RUN) mem[prog_addr] <= prog_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      PC <= '0;
      RegAddr <= '0;
      ALUCode <= '1;
      str <= '0;
    end else begin
      state <= state_d;
      PC <= pc_d;
      RegAddr <= reg_d;
      ALUCode <= alu_d;
      str <= str_d;
    end
  // abort outranks the fetched word; outputs default to NOP
  always_comb begin
    state_d = state;
    pc_d = PC;
    reg_d = '0;
    alu_d = '1;
    str_d = '0;
    if (state != RUN) begin
      if (start) begin
        state_d = RUN;
        pc_d = '0;
      end
    end else if (abort) state_d = IDLE;
    else if (adv) begin
      case (kind)
        2'b00: begin
          reg_d = NREG'(1) << field[RW-1:0];
          alu_d = instr[4 +: ALUW];
          str_d = instr[3:0];
          pc_d = pc_inc;
        end
        2'b01: pc_d = field;
        2'b10: pc_d = CY_in ? field : pc_inc;
        2'b11: state_d = HALTED;
      endcase
    end
  end
endmodule

// File: tb/tb_pp_sequencer.sv
// tb_pp_sequencer: directed checks of load/run, JC, wrap, write guard, abort and reset.
// Define PP_SEQ_STEP_EN to also exercise the step gate.
`ifndef LD
`define LD 3'b000
`endif
`ifndef ADD
`define ADD 3'b001
`endif
`ifndef SUB
`define SUB 3'b010
`endif
`ifndef ST
`define ST 3'b101
`endif
module tb_pp_sequencer;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, prog_we = 0, CY_in = 0, step = 1;
  logic [4:0] prog_addr = '0;
  logic [13:0] prog_wdata = '0;
  logic busy, halted, Reg_CE, CY_CE, A_CE, ResetCY;
  logic [4:0] PC;
  logic [3:0] RegAddr;
  logic [2:0] ALUCode;
  int vec = 0, miss = 0;
  localparam logic [10:0] NOP = {4'b0000, 3'b111, 4'b0000};
  pp_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef PP_SEQ_STEP_EN
    .step(step),
`endif
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata), .CY_in(CY_in),
    .busy(busy), .halted(halted), .PC(PC), .RegAddr(RegAddr), .ALUCode(ALUCode),
    .Reg_CE(Reg_CE), .CY_CE(CY_CE), .A_CE(A_CE), .ResetCY(ResetCY)
  );
  always #5 clk = ~clk;
  function automatic logic [13:0] w(logic [1:0] k, logic [4:0] f, logic [2:0] a, logic [3:0] s);
    return {k, f, a, s};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic st(string tag, logic b, logic h, logic [4:0] p, logic [10:0] c);
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_halted"}, 32'(halted), 32'(h));
    chk({tag, "_pc"}, 32'(PC), 32'(p));
    chk({tag, "_ctl"}, 32'({RegAddr, ALUCode, Reg_CE, CY_CE, A_CE, ResetCY}), 32'(c));
  endtask
  task automatic load(logic [4:0] a, logic [13:0] d);
    prog_we = 1; prog_addr = a; prog_wdata = d;
    tick;
    prog_we = 0;
  endtask
  initial begin
    tick; tick;
    st("reset", 0, 0, 0, NOP);
    rst_n = 1;
    tick;
    st("idle", 0, 0, 0, NOP);
    load(0, w(2'b00, 5'd3, `ADD, 4'b0110));
    load(1, w(2'b00, 5'd0, `ST, 4'b1000));
    load(2, w(2'b11, 5'd0, 3'b000, 4'b0000));
    start = 1; tick; start = 0;
    st("run0", 1, 0, 0, NOP);
    tick; st("run1", 1, 0, 1, {4'b1000, `ADD, 4'b0110});
    tick; st("run2", 1, 0, 2, {4'b0001, `ST, 4'b1000});
    tick; st("halt", 0, 1, 2, NOP);
    tick; st("halt_hold", 0, 1, 2, NOP);
    load(0, w(2'b10, 5'd5, 3'b000, 4'b0000));
    load(5, w(2'b11, 5'd0, 3'b000, 4'b0000));
    CY_in = 1; start = 1; tick; start = 0;
    tick; st("jc_taken", 1, 0, 5, NOP);
    tick; st("jc_halt", 0, 1, 5, NOP);
    CY_in = 0; start = 1; tick; start = 0;
    tick; st("jc_fall", 1, 0, 1, NOP);
    tick; st("jc_exec", 1, 0, 2, {4'b0001, `ST, 4'b1000});
    tick; st("jc_halt2", 0, 1, 2, NOP);
    load(0, w(2'b01, 5'd31, 3'b000, 4'b0000));
    load(31, w(2'b00, 5'd2, `SUB, 4'b0001));
    start = 1; tick; start = 0;
    tick; st("jmp31", 1, 0, 31, NOP);
    tick; st("wrap", 1, 0, 0, {4'b0100, `SUB, 4'b0001});
    tick; st("jmp31b", 1, 0, 31, NOP);
    prog_we = 1; prog_addr = 0; prog_wdata = w(2'b11, 5'd0, 3'b000, 4'b0000);
    start = 1;
    tick; prog_we = 0; start = 0;
    st("guard_wrap", 1, 0, 0, {4'b0100, `SUB, 4'b0001});
    tick; st("guard_kept", 1, 0, 31, NOP);
    abort = 1; tick; abort = 0;
    st("abort", 0, 0, 31, NOP);
    tick; st("abort_idle", 0, 0, 31, NOP);
    start = 1; tick; start = 0;
    tick; tick;
    st("pre_rst", 1, 0, 0, {4'b0100, `SUB, 4'b0001});
    rst_n = 0; #1;
    st("async_rst", 0, 0, 0, NOP);
    tick; rst_n = 1;
    start = 1; prog_we = 1; prog_addr = 0; prog_wdata = w(2'b11, 5'd0, 3'b000, 4'b0000);
    tick; start = 0; prog_we = 0;
    st("st_we", 1, 0, 0, NOP);
    tick; st("st_we_halt", 0, 1, 0, NOP);
`ifdef PP_SEQ_STEP_EN
    load(0, w(2'b00, 5'd1, `LD, 4'b0010));
    load(1, w(2'b11, 5'd0, 3'b000, 4'b0000));
    step = 0; start = 1; tick; start = 0;
    for (int i = 0; i < 3; i++) begin
      tick; st("step0", 1, 0, 0, NOP);
    end
    step = 1; tick;
    st("step1", 1, 0, 1, {4'b0010, `LD, 4'b0010});
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
